risc_datapath: RTL and testbench
================================

Name: risc_datapath

Overview:
- 32-bit single-bus datapath for the RISC CPU.
- Contains:
  - sixteen general registers R0–R15
  - PC, IR, MAR, MDR
  - Y (ALU A-operand latch)
  - 64-bit Z (ALU result)
  - HI, LO
  - ALU
- An external control unit (or bench) drives every register load enable, every bus-out select and the ALU opcode.
- The block has no data outputs. State is observed through internal registers, which are named exactly: bus, R[0:15], PC, IR, MAR, MDR, Y, Z, HI, LO.

Parameters:
- none (word width fixed at 32; register count fixed at 16)

Ports:
- Clock in 1 — system clock; all registers load on the rising edge.
- clear in 1 — asynchronous, active-low reset.
- Mdatain in 32 — memory read data.
- Read in 1 — MDR input select: 1 = Mdatain, 0 = bus.
- IncPC in 1 — with PCin, load PC+1 instead of bus.
- Rin in 16 — bit n loads Rn from bus.
- Rout in 16 — bit n drives Rn onto bus.
- PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin in 1 each — load enables.
- PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout in 1 each — bus drive selects.
- opcode in 5 — ALU operation.

Behaviour:
- Reset (clear = 0, asynchronous): R0–R15, PC, IR, MAR, MDR, Y, Z, HI and LO all become 0.
- Bus: a combinational 32-bit mux.
  - Priority, highest first: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, C.
  - C = IR[18:0] sign-extended to 32 bits.
  - No select asserted → bus = 0.
  - Multiple selects asserted: resolved by the priority order (a control error, but deterministic).
- Register loads (rising edge):
  - Rn ← bus if Rin[n].
  - Y, MAR, IR, HI, LO ← bus on their enables.
  - MDR ← (Read ? Mdatain : bus) if MDRin.
  - PC ← (IncPC ? PC+1 : bus) if PCin. IncPC without PCin has no effect.
- ALU:
  - Combinational. A = Y, B = bus, shift amount = B[4:0]. Result is 64 bits.
  - Z ← result when Zin.
  - For all 32-bit operations, Z[63:32] = 0.
- Opcodes:
  - 00000/00001/00010 (ld/ldi/st address), 00011 add, 01100 addi: A+B, wrap-around, no carry kept.
  - 00100 sub: A−B.
  - 00101 and / 01101 andi: A&B.
  - 00110 or / 01110 ori: A|B.
  - 00111 shr: logical right.
  - 01000 shra: arithmetic right, sign-filling.
  - 01001 shl: left.
  - 01010 ror, 01011 rol: rotate.
  - Shift amount 0 → A unchanged.
  - 01111 mul: signed 32×32 product.
  - 10000 div: signed. Z[31:0] = quotient, Z[63:32] = remainder.
  - Divide by zero: Z[31:0] = 32'hFFFFFFFF and Z[63:32] = A.
  - 10001 neg: 0−B.
  - 10010 not: ~B.
  - 10011–11111: result 0.
- Latency: one bus transfer per clock. A full ALU op takes two cycles:
  - cycle 1: Yin with the A source driving the bus;
  - cycle 2: Zin with the B source driving the bus.
  - The result is then readable via Zlowout / Zhighout on the following cycle.
- Simultaneous load and drive of the same register: the register takes the old bus value. Reads are combinational, writes occur on the edge.
- Reset mid-operation: clears state immediately; no partial results are retained.

Decomposition:
- Shared package risc_pkg:
  - 5-bit opcode constants (OP_ADD … OP_NOT);
  - WORD_W = 32, NREGS = 16.
- One sub-module, risc_alu: combinational (A, B, opcode → 64-bit result).
- Registers, bus mux, MDR mux and PC incrementer live in the top level.

Test Plan:
- Reset: clear = 0 mid-run → all registers read 0. Release, then MDRout with nothing loaded → bus = 0.
- Register load: Mdatain = 0xF0000012, Read = 1, MDRin → MDR = 0xF0000012; next cycle MDRout + Rin[3] → R3 = 0xF0000012. Repeat with 0x14 → R5 and 0x18 → R1.
- shra:
  - R3out + Yin, then R5out + opcode 01000 + Zin, then Zlowout + Rin[1].
  - Required: R1 = 0xFFFFFF00; Z[63:32] = 0.
  - Variant with R3 = 0x70000012 → R1 = 0x00000700.
- Fetch: PCout + MARin → MAR = 0. PCin + IncPC → PC = 1. Mdatain = 0x28918000, Read, MDRin, then MDRout + IRin → IR = 0x28918000.
- Arithmetic sweep:
  - add 0xFFFFFFFF+1 → Zlow 0;
  - mul 0xFFFFFFFE×3 → Z = 0xFFFFFFFF_FFFFFFFA;
  - div 7/−2 → Zlow = 0xFFFFFFFD, Zhigh = 1;
  - div by 0 → Zlow = 0xFFFFFFFF;
  - rol 0x80000001 by 1 → 0x00000003.
- Bus contention: R1out + R5out together → bus = R1. Cout with IR[18:0] = 0x40000 → bus = 0xFFFC0000.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared constants for the RISC single-bus datapath.
// Holds the word width, the general register count and the 5-bit ALU
// opcode encodings that the control unit places on the opcode port.
package risc_pkg;

  localparam int WORD_W = 32;
  localparam int NREGS  = 16;

  // Memory-reference instructions use the adder to form their address.
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/risc_alu.sv
// risc_alu: purely combinational ALU of the RISC datapath.
// Ports:
//   a      in  32 - A operand (from the Y latch)
//   b      in  32 - B operand (the bus); b[4:0] is the shift/rotate amount
//   opcode in  5  - operation select (risc_pkg::OP_*)
//   result out 64 - result; upper half is 0 except for mul and div
module risc_alu
  import risc_pkg::*;
(
  input  logic [WORD_W-1:0]   a,
  input  logic [WORD_W-1:0]   b,
  input  logic [4:0]          opcode,
  output logic [2*WORD_W-1:0] result
);

  logic        [4:0]        sh_s;
  logic signed [WORD_W-1:0] sa_s;
  logic signed [WORD_W-1:0] sb_s;
  logic signed [WORD_W-1:0] quo_s;
  logic signed [WORD_W-1:0] rem_s;
  logic        [2*WORD_W-1:0] prod_s;

  assign sh_s = b[4:0];

  // Signed divide with the divisor forced non-zero so the divider never sees 0.
  always_comb begin
    sa_s = $signed(a);
    if (b == 32'd0) begin
      sb_s = 32'sd1;
    end else begin
      sb_s = $signed(b);
    end
    quo_s = sa_s / sb_s;
    rem_s = sa_s % sb_s;
  end

  // Sign-extending both operands to 64 bits makes an unsigned 64-bit
  // multiply produce the exact signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Operation select.
  always_comb begin
    result = 64'd0;
    case (opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: result = {32'd0, a + b};
      OP_SUB:          result = {32'd0, a - b};
      OP_AND, OP_ANDI: result = {32'd0, a & b};
      OP_OR,  OP_ORI:  result = {32'd0, a | b};
      OP_SHR:          result = {32'd0, a >> sh_s};
      OP_SHRA:         result = {32'd0, 32'($signed(a) >>> sh_s)};
      OP_SHL:          result = {32'd0, a << sh_s};
      // A shift by 32 yields 0, so an amount of 0 leaves A unchanged.
      OP_ROR:          result = {32'd0, (a >> sh_s) | (a << (6'd32 - {1'b0, sh_s}))};
      OP_ROL:          result = {32'd0, (a << sh_s) | (a >> (6'd32 - {1'b0, sh_s}))};
      OP_MUL:          result = prod_s;
      OP_DIV: begin
        if (b == 32'd0) begin
          result = {a, 32'hFFFF_FFFF};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // Most-negative / -1 overflows: quotient wraps, remainder 0.
          result = {32'd0, 32'h8000_0000};
        end else begin
          result = {rem_s, quo_s};
        end
      end
      OP_NEG:          result = {32'd0, 32'd0 - b};
      OP_NOT:          result = {32'd0, ~b};
      default:         result = 64'd0;
    endcase
  end

endmodule

// File: rtl/risc_datapath.sv
// risc_datapath: 32-bit single-bus datapath (R0-R15, PC, IR, MAR, MDR, Y,
// 64-bit Z, HI, LO and the ALU). All control comes from outside; state is
// observed through the internal registers.
// Ports:
//   Clock          in  1  - rising-edge clock
//   clear          in  1  - asynchronous active-low reset
//   Mdatain        in  32 - memory read data
//   Read           in  1  - MDR source: 1 = Mdatain, 0 = bus
//   IncPC          in  1  - with PCin, PC <= PC+1 instead of bus
//   Rin / Rout     in  16 - per-register load enables / bus drive selects
//   PCin..IRin     in  1  - load enables
//   PCout..Cout    in  1  - bus drive selects
//   opcode         in  5  - ALU operation
module risc_datapath
  import risc_pkg::*;
(
  input  logic              Clock,
  input  logic              clear,
  input  logic [WORD_W-1:0] Mdatain,
  input  logic              Read,
  input  logic              IncPC,
  input  logic [NREGS-1:0]  Rin,
  input  logic [NREGS-1:0]  Rout,
  input  logic              PCin,
  input  logic              Zin,
  input  logic              MDRin,
  input  logic              MARin,
  input  logic              Yin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              IRin,
  input  logic              PCout,
  input  logic              Zhighout,
  input  logic              Zlowout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              MDRout,
  input  logic              Cout,
  input  logic [4:0]        opcode
);

  logic [WORD_W-1:0]   R [0:NREGS-1];
  logic [WORD_W-1:0]   PC, IR, MAR, MDR, Y, HI, LO;
  logic [2*WORD_W-1:0] Z;
  logic [WORD_W-1:0]   bus;

  logic [WORD_W-1:0]   c_ext_s;
  logic [WORD_W-1:0]   rsel_s;
  logic [WORD_W-1:0]   pc_d;
  logic [WORD_W-1:0]   mdr_d;
  logic [2*WORD_W-1:0] alu_s;

  // Immediate constant: IR[18:0] sign-extended.
  assign c_ext_s = {{13{IR[18]}}, IR[18:0]};

  // Register-file bus source; scanning downward lets the lowest index win.
  always_comb begin
    rsel_s = 32'd0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      rsel_s = Rout[i] ? R[i] : rsel_s;
    end
  end

  // Bus mux in fixed priority order; no select gives 0.
  always_comb begin
    bus = 32'd0;
    if (|Rout) begin
      bus = rsel_s;
    end else if (HIout) begin
      bus = HI;
    end else if (LOout) begin
      bus = LO;
    end else if (Zhighout) begin
      bus = Z[63:32];
    end else if (Zlowout) begin
      bus = Z[31:0];
    end else if (PCout) begin
      bus = PC;
    end else if (MDRout) begin
      bus = MDR;
    end else if (Cout) begin
      bus = c_ext_s;
    end else begin
      bus = 32'd0;
    end
  end

  // Next-state for PC (incrementer or bus) and MDR (memory or bus).
  always_comb begin
    pc_d  = PC;
    mdr_d = MDR;
    if (PCin) begin
      pc_d = IncPC ? (PC + 32'd1) : bus;
    end else begin
      pc_d = PC;
    end
    if (MDRin) begin
      mdr_d = Read ? Mdatain : bus;
    end else begin
      mdr_d = MDR;
    end
  end

  risc_alu u_alu (
    .a      (Y),
    .b      (bus),
    .opcode (opcode),
    .result (alu_s)
  );

  // Datapath registers: asynchronous clear, bus loads on the rising edge.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) begin
        R[i] <= 32'd0;
      end
      PC  <= 32'd0;
      IR  <= 32'd0;
      MAR <= 32'd0;
      MDR <= 32'd0;
      Y   <= 32'd0;
      Z   <= 64'd0;
      HI  <= 32'd0;
      LO  <= 32'd0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (Rin[i]) begin
          R[i] <= bus;
        end
      end
      PC  <= pc_d;
      MDR <= mdr_d;
      if (IRin)  IR  <= bus;
      if (MARin) MAR <= bus;
      if (Yin)   Y   <= bus;
      if (Zin)   Z   <= alu_s;
      if (HIin)  HI  <= bus;
      if (LOin)  LO  <= bus;
    end
  end

endmodule

// File: tb/tb_risc_datapath.sv
// Directed self-checking bench for risc_datapath. Controls change 1 time
// unit after each rising edge; registers and the bus are sampled there.
module tb_risc_datapath;

  logic        Clock, clear, Read, IncPC;
  logic [31:0] Mdatain;
  logic [15:0] Rin, Rout;
  logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
  logic [4:0]  opcode;

  int errors = 0;
  int checks = 0;

  risc_datapath dut (
    .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IRin(IRin), .PCout(PCout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .opcode(opcode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Read = 1'b0; IncPC = 1'b0; Rin = 16'd0; Rout = 16'd0;
    PCin = 1'b0; Zin = 1'b0; MDRin = 1'b0; MARin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; IRin = 1'b0; PCout = 1'b0; Zhighout = 1'b0;
    Zlowout = 1'b0; HIout = 1'b0; LOout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick(); idle();
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1'b1; Rin = 16'd1 << n;
    tick(); idle();
  endtask

  // A via MDR into Y, then B via MDR onto the bus with Zin.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    mem_to_mdr(a);
    MDRout = 1'b1; Yin = 1'b1;
    tick(); idle();
    mem_to_mdr(b);
    MDRout = 1'b1; opcode = op; Zin = 1'b1;
    tick(); idle();
  endtask

  task automatic shra_seq();
    Rout = 16'd1 << 3; Yin = 1'b1;
    tick(); idle();
    Rout = 16'd1 << 5; opcode = 5'b01000; Zin = 1'b1;
    tick(); idle();
    Zlowout = 1'b1; Rin = 16'd1 << 1;
    tick(); idle();
  endtask

  initial begin
    idle();
    Mdatain = 32'd0; opcode = 5'd0; clear = 1'b0;
    repeat (2) tick();
    chk("rst_R0", dut.R[0], 64'd0);
    chk("rst_R15", dut.R[15], 64'd0);
    chk("rst_PC", dut.PC, 64'd0);
    chk("rst_Z", dut.Z, 64'd0);
    chk("rst_HI", dut.HI, 64'd0);
    clear = 1'b1;
    tick();

    // Load some state, then clear asynchronously mid-cycle.
    mem_to_mdr(32'hDEAD_BEEF);
    chk("mdr_load", dut.MDR, 64'h0000_0000_DEAD_BEEF);
    MDRout = 1'b1; Rin = 16'd1; PCin = 1'b1;
    tick(); idle();
    chk("pc_from_bus", dut.PC, 64'h0000_0000_DEAD_BEEF);
    #3 clear = 1'b0;
    #1;
    chk("clr_MDR", dut.MDR, 64'd0);
    chk("clr_R0", dut.R[0], 64'd0);
    chk("clr_PC", dut.PC, 64'd0);
    #1 clear = 1'b1;
    MDRout = 1'b1;
    #1 chk("bus_mdr_empty", dut.bus, 64'd0);
    idle();
    tick();

    // Register loads through MDR.
    load_reg(3, 32'hF000_0012);
    chk("R3_load", dut.R[3], 64'h0000_0000_F000_0012);
    load_reg(5, 32'h0000_0014);
    chk("R5_load", dut.R[5], 64'h14);
    load_reg(1, 32'h0000_0018);
    chk("R1_load", dut.R[1], 64'h18);

    // shra: 0xF0000012 >>> 20, then 0x70000012 >>> 20.
    shra_seq();
    chk("shra_neg_R1", dut.R[1], 64'h0000_0000_FFFF_FF00);
    chk("shra_Zhi", dut.Z[63:32], 64'd0);
    load_reg(3, 32'h7000_0012);
    shra_seq();
    chk("shra_pos_R1", dut.R[1], 64'h0000_0700);

    // Fetch.
    load_reg(7, 32'h1234_5678);
    Rout = 16'd1 << 7; MARin = 1'b1;
    tick(); idle();
    chk("mar_preload", dut.MAR, 64'h1234_5678);
    PCout = 1'b1; MARin = 1'b1;
    tick(); idle();
    chk("fetch_MAR", dut.MAR, 64'd0);
    PCin = 1'b1; IncPC = 1'b1;
    tick(); idle();
    chk("fetch_PC", dut.PC, 64'd1);
    IncPC = 1'b1;
    tick(); idle();
    chk("incpc_alone", dut.PC, 64'd1);
    mem_to_mdr(32'h2891_8000);
    MDRout = 1'b1; IRin = 1'b1;
    tick(); idle();
    chk("fetch_IR", dut.IR, 64'h2891_8000);

    // Arithmetic sweep.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 5'b00011);
    chk("add_wrap", dut.Z, 64'd0);
    run_op(32'hFFFF_FFFE, 32'h0000_0003, 5'b01111);
    chk("mul_signed", dut.Z, 64'hFFFF_FFFF_FFFF_FFFA);
    Zhighout = 1'b1;
    #1 chk("mul_zhigh_bus", dut.bus, 64'hFFFF_FFFF);
    idle();
    run_op(32'h0000_0007, 32'hFFFF_FFFE, 5'b10000);
    chk("div_signed", dut.Z, 64'h0000_0001_FFFF_FFFD);
    Zlowout = 1'b1;
    #1 chk("div_zlow_bus", dut.bus, 64'hFFFF_FFFD);
    idle();
    run_op(32'h0000_0005, 32'h0000_0000, 5'b10000);
    chk("div_by_zero", dut.Z, 64'h0000_0005_FFFF_FFFF);
    run_op(32'h8000_0001, 32'h0000_0001, 5'b01011);
    chk("rol", dut.Z, 64'h0000_0003);
    run_op(32'h0000_0001, 32'h0000_0001, 5'b01010);
    chk("ror", dut.Z, 64'h8000_0000);
    run_op(32'h0000_1234, 32'h0000_0000, 5'b01001);
    chk("shl_zero", dut.Z, 64'h1234);
    run_op(32'h8000_0000, 32'h0000_0004, 5'b00111);
    chk("shr", dut.Z, 64'h0800_0000);
    run_op(32'h0000_0005, 32'h0000_0007, 5'b00100);
    chk("sub", dut.Z, 64'hFFFF_FFFE);
    run_op(32'h0000_00F0, 32'h0000_003C, 5'b00101);
    chk("and", dut.Z, 64'h30);
    run_op(32'h0000_00F0, 32'h0000_000F, 5'b01110);
    chk("ori", dut.Z, 64'hFF);
    run_op(32'h0000_0000, 32'h0000_0005, 5'b10001);
    chk("neg", dut.Z, 64'hFFFF_FFFB);
    run_op(32'h0000_0000, 32'h0F0F_0000, 5'b10010);
    chk("not", dut.Z, 64'hF0F0_FFFF);
    run_op(32'h0000_0003, 32'h0000_0004, 5'b10011);
    chk("unused_op", dut.Z, 64'd0);

    // Bus contention and the sign-extended constant.
    Rout = (16'd1 << 1) | (16'd1 << 5);
    #1 chk("bus_prio_R1", dut.bus, 64'h0000_0700);
    idle();
    load_reg(9, 32'h0BAD_F00D);
    Rout = 16'd1 << 9; HIin = 1'b1;
    tick(); idle();
    HIout = 1'b1; PCout = 1'b1;
    #1 chk("bus_prio_HI", dut.bus, 64'h0BAD_F00D);
    idle();
    mem_to_mdr(32'h0004_0000);
    MDRout = 1'b1; IRin = 1'b1;
    tick(); idle();
    Cout = 1'b1;
    #1 chk("bus_cout", dut.bus, 64'hFFFC_0000);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
